// File: rtl/pcie_dll_tx.sv
// PCIe data-link-layer transmit path: sequence tagging, LCRC framing,
// replay buffer with ACK/NAK purge, replay timer and replay-number rollover.
module pcie_dll_tx #(
    parameter int TLP_W          = 256,
    parameter int RB_DEPTH       = 4,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tlp_valid_i,
    input  logic [TLP_W-1:0]    tlp_i,
    output logic                tlp_ready_o,
    input  logic                ack_nak_valid_i,
    input  logic                ack_nak_is_nak_i,
    input  logic [11:0]         ack_nak_seq_i,
    output logic                ack_nak_ready_o,
    output logic                pkt_valid_o,
    output logic [TLP_W+47:0]   pkt_o,
    input  logic                pkt_ready_i,
    output logic                retrain_req_o
);
    localparam int AW = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = TLP_W + 12;
    localparam int TW = (REPLAY_TIMEOUT > 2) ? $clog2(REPLAY_TIMEOUT) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(RB_DEPTH);
    localparam logic [TW-1:0] TMR_LAST = TW'(REPLAY_TIMEOUT - 1);

    // state | meaning
    // NORMAL | accept new TLPs and ACK/NAK DLLPs, replay timer running
    // REPLAY | re-send every buffered entry oldest-first, inputs stalled
    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;

    function automatic logic [31:0] lcrc(input logic [EW+3:0] din);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = EW + 3; i >= 0; i--) begin
            fb = c[31] ^ din[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
        end
        return ~c;
    endfunction

    logic [0:0]        state_q, state_d;
    logic [11:0]       next_seq_q, next_seq_d;
    logic [CW-1:0]     count_q, count_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        replay_num_q, replay_num_d;
    logic              retrain_q, retrain_d;
    logic [CW-1:0]     rp_idx_q, rp_idx_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [TLP_W+47:0] pkt_q, pkt_d;

    logic [EW-1:0]     rb_mem [RB_DEPTH];
    logic [EW-1:0]     rb_rd;
    logic [EW-1:0]     ld_entry;
    logic [11:0]       oldest_seq, diff;
    logic [CW-1:0]     purge_n;
    logic [1:0]        rn_base;
    logic              out_free, out_xfer, tlp_xfer, an_acc;
    logic              in_range, purge, nak_go, expire, go, load_rp;

    assign out_free        = ~pkt_valid_q | pkt_ready_i;
    assign out_xfer        = pkt_valid_q & pkt_ready_i;
    assign ack_nak_ready_o = rst_n & (state_q == ST_NORMAL);
    assign tlp_ready_o     = rst_n & (state_q == ST_NORMAL) & (count_q < DEPTH_C) & out_free;
    assign tlp_xfer        = tlp_valid_i & tlp_ready_o;
    assign an_acc          = ack_nak_valid_i & ack_nak_ready_o;
    assign rb_rd           = rb_mem[rd_ptr_q + AW'(rp_idx_q)];
    assign pkt_valid_o     = pkt_valid_q;
    assign pkt_o           = pkt_q;
    assign retrain_req_o   = retrain_q;

    always_comb begin
        state_d      = state_q;
        next_seq_d   = next_seq_q + 12'(tlp_xfer);
        wr_ptr_d     = wr_ptr_q + AW'(tlp_xfer);
        rp_idx_d     = rp_idx_q;
        pkt_valid_d  = pkt_valid_q;
        pkt_d        = pkt_q;
        retrain_d    = 1'b0;
        ld_entry     = {next_seq_q, tlp_i};

        // Sequence numbers in the buffer are contiguous, so the oldest one
        // follows from next_seq and the occupancy.
        oldest_seq = next_seq_q - 12'(count_q);
        diff       = ack_nak_seq_i - oldest_seq;
        in_range   = diff < 12'(count_q);
        purge      = an_acc & in_range;
        purge_n    = purge ? CW'(diff + 12'd1) : '0;
        nak_go     = an_acc & ack_nak_is_nak_i & (in_range | (diff == 12'hFFF));
        rd_ptr_d   = rd_ptr_q + AW'(purge_n);
        count_d    = count_q + CW'(tlp_xfer) - purge_n;

        expire = (state_q == ST_NORMAL) & (timer_q == TMR_LAST) & ~purge;
        go     = (state_q == ST_NORMAL) & (nak_go | expire) & (count_d != '0);

        load_rp = (state_q == ST_REPLAY) & out_free & (rp_idx_q != count_q);
        if (load_rp) ld_entry = rb_rd;
        if (tlp_xfer | load_rp) begin
            pkt_d       = {4'b0, ld_entry, lcrc({4'b0, ld_entry})};
            pkt_valid_d = 1'b1;
        end else if (out_xfer) begin
            pkt_valid_d = 1'b0;
        end

        if (state_q == ST_REPLAY) begin
            if (load_rp) rp_idx_d = rp_idx_q + CW'(1);
            if ((rp_idx_q == count_q) && out_xfer) state_d = ST_NORMAL;
        end

        timer_d = timer_q;
        if ((state_q == ST_NORMAL) && (count_q != '0)) timer_d = timer_q + TW'(1);
        if (go || purge || (count_d == '0)) timer_d = '0;

        rn_base      = purge ? 2'd0 : replay_num_q;
        replay_num_d = rn_base;
        if (go) begin
            state_d      = ST_REPLAY;
            rp_idx_d     = '0;
            replay_num_d = rn_base + 2'd1;
            retrain_d    = (rn_base == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            next_seq_q   <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            timer_q      <= '0;
            replay_num_q <= '0;
            retrain_q    <= 1'b0;
            rp_idx_q     <= '0;
            pkt_valid_q  <= 1'b0;
            pkt_q        <= '0;
        end else begin
            state_q      <= state_d;
            next_seq_q   <= next_seq_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            timer_q      <= timer_d;
            replay_num_q <= replay_num_d;
            retrain_q    <= retrain_d;
            rp_idx_q     <= rp_idx_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_q        <= pkt_d;
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (tlp_xfer) rb_mem[wr_ptr_q] <= {next_seq_q, tlp_i};
    end
endmodule

// File: tb/tb_pcie_dll_tx.sv
// Randomized and directed bench for pcie_dll_tx against a queue-based
// reference model of the data-link transmit rules.
module tb_pcie_dll_tx;
    localparam int TLP_W = 64;
    localparam int RB    = 4;
    localparam int TO    = 16;
    localparam int FW    = TLP_W + 48;

    typedef struct packed {
        logic [11:0]      seq;
        logic [TLP_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              tlp_valid_i = 1'b0;
    logic [TLP_W-1:0]  tlp_i = '0;
    logic              tlp_ready_o;
    logic              ack_nak_valid_i = 1'b0;
    logic              ack_nak_is_nak_i = 1'b0;
    logic [11:0]       ack_nak_seq_i = '0;
    logic              ack_nak_ready_o;
    logic              pkt_valid_o;
    logic [FW-1:0]     pkt_o;
    logic              pkt_ready_i = 1'b0;
    logic              retrain_req_o;

    pcie_dll_tx #(.TLP_W(TLP_W), .RB_DEPTH(RB), .REPLAY_TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tlp_valid_i      (tlp_valid_i),
        .tlp_i            (tlp_i),
        .tlp_ready_o      (tlp_ready_o),
        .ack_nak_valid_i  (ack_nak_valid_i),
        .ack_nak_is_nak_i (ack_nak_is_nak_i),
        .ack_nak_seq_i    (ack_nak_seq_i),
        .ack_nak_ready_o  (ack_nak_ready_o),
        .pkt_valid_o      (pkt_valid_o),
        .pkt_o            (pkt_o),
        .pkt_ready_i      (pkt_ready_i),
        .retrain_req_o    (retrain_req_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    ent_t          m_buf[$];
    ent_t          m_pend[$];
    logic [11:0]   m_next_seq;
    bit            m_replay, m_out_valid, m_out_last, m_retrain;
    logic [FW-1:0] m_out_pkt;
    int            m_timer;
    int            m_rnum;

    // observation helpers
    logic [11:0] obs_seq[$];
    int          n_acc, n_retrain;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] frame(input ent_t e);
        logic [TLP_W+15:0] m;
        logic [31:0]       c;
        m = {4'b0, e.seq, e.d};
        c = 32'hFFFF_FFFF;
        for (int i = TLP_W + 15; i >= 0; i--)
            c = (c << 1) ^ (((c[31] ^ m[i]) != 1'b0) ? 32'h04C1_1DB7 : 32'h0);
        return {m, ~c};
    endfunction

    function automatic logic [TLP_W-1:0] rnd_tlp();
        return {$urandom, $urandom};
    endfunction

    task automatic model_clear();
        m_buf.delete();
        m_pend.delete();
        m_next_seq  = '0;
        m_replay    = 0;
        m_out_valid = 0;
        m_out_last  = 0;
        m_retrain   = 0;
        m_out_pkt   = '0;
        m_timer     = 0;
        m_rnum      = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tlp_valid_i = 1'b0; ack_nak_valid_i = 1'b0; ack_nak_is_nak_i = 1'b0;
        ack_nak_seq_i = '0; pkt_ready_i = 1'b0; tlp_i = '0;
        #1;
        check("rst_tlp_ready", tlp_ready_o, 0);
        check("rst_ack_ready", ack_nak_ready_o, 0);
        check("rst_pkt_valid", pkt_valid_o, 0);
        check("rst_pkt_o", pkt_o, 0);
        check("rst_retrain", retrain_req_o, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_tlp_ready", tlp_ready_o, 1);
        check("post_rst_ack_ready", ack_nak_ready_o, 1);
    endtask

    task automatic step(input bit tv, input logic [TLP_W-1:0] d, input bit av, input bit an,
                        input logic [11:0] s, input bit pr);
        bit tready, aready, out_free, out_xfer, purged, nak_ok, expire, go, was_replay;
        int old_size, base;
        logic [11:0] oldest, diff;
        ent_t e;
        @(negedge clk);
        tlp_valid_i = tv; tlp_i = d; ack_nak_valid_i = av; ack_nak_is_nak_i = an;
        ack_nak_seq_i = s; pkt_ready_i = pr;
        #1;
        old_size   = m_buf.size();
        was_replay = m_replay;
        out_free   = !m_out_valid || pr;
        out_xfer   = m_out_valid && pr;
        tready     = !m_replay && (old_size < RB) && out_free;
        aready     = !m_replay;
        check("tlp_ready", tlp_ready_o, tready);
        check("ack_ready", ack_nak_ready_o, aready);
        check("pkt_valid", pkt_valid_o, m_out_valid);
        check("pkt_o", pkt_o, m_out_pkt);
        check("retrain", retrain_req_o, m_retrain);
        if (pkt_valid_o && pr) obs_seq.push_back(pkt_o[TLP_W+43:TLP_W+32]);
        if (tv && tlp_ready_o) n_acc++;
        if (retrain_req_o) n_retrain++;

        purged = 0;
        nak_ok = 0;
        if (aready && av) begin
            oldest = m_next_seq - 12'(old_size);
            diff   = s - oldest;
            if (int'(diff) < old_size) begin
                purged = 1;
                repeat (int'(diff) + 1) void'(m_buf.pop_front());
            end
            nak_ok = an && (purged || diff == 12'hFFF);
        end

        m_retrain = 0;
        if (tready && tv) begin
            e.seq = m_next_seq;
            e.d   = d;
            m_buf.push_back(e);
            m_out_pkt   = frame(e);
            m_out_valid = 1;
            m_out_last  = 0;
            m_next_seq  = m_next_seq + 12'd1;
        end else if (was_replay) begin
            if (out_free && m_pend.size() > 0) begin
                e = m_pend.pop_front();
                m_out_pkt   = frame(e);
                m_out_valid = 1;
                m_out_last  = (m_pend.size() == 0);
            end else if (out_xfer) begin
                m_out_valid = 0;
                if (m_out_last) begin
                    m_replay   = 0;
                    m_out_last = 0;
                end
            end
        end else if (out_xfer) begin
            m_out_valid = 0;
        end

        expire = !was_replay && (m_timer == TO - 1) && !purged;
        go     = !was_replay && (nak_ok || expire) && (m_buf.size() > 0);
        if (go) begin
            m_replay  = 1;
            m_pend    = m_buf;
            base      = purged ? 0 : m_rnum;
            m_retrain = (base == 3);
            m_rnum    = (base + 1) % 4;
            m_timer   = 0;
        end else begin
            if (purged) m_rnum = 0;
            if (purged || m_buf.size() == 0) m_timer = 0;
            else if (!was_replay && old_size > 0) m_timer++;
        end
    endtask

    task automatic idle(input int n, input bit pr);
        repeat (n) step(0, '0, 0, 0, '0, pr);
    endtask

    initial begin
        logic [11:0] s;
        // basic send
        do_reset();
        obs_seq.delete();
        repeat (3) step(1, rnd_tlp(), 0, 0, '0, 1);
        idle(2, 1);
        check("basic_n", obs_seq.size(), 3);
        check("basic_seq0", obs_seq[0], 0);
        check("basic_seq1", obs_seq[1], 1);
        check("basic_seq2", obs_seq[2], 2);

        // backpressure, then fill to depth
        do_reset();
        n_acc = 0;
        repeat (5) step(1, rnd_tlp(), 0, 0, '0, 0);
        check("bp_accepted", n_acc, 1);
        repeat (5) step(1, rnd_tlp(), 0, 0, '0, 1);
        check("full_accepted", n_acc, 4);

        // ACK purge 4->2, then TLP with simultaneous ACK 3 -> count 1
        step(0, '0, 1, 0, 12'd1, 1);
        step(1, rnd_tlp(), 1, 0, 12'd3, 1);
        n_acc = 0;
        repeat (5) step(1, rnd_tlp(), 0, 0, '0, 1);
        check("purge_refill", n_acc, 3);

        // NAK replay of 6,7 after buffering 5..7
        do_reset();
        repeat (4) step(1, rnd_tlp(), 0, 0, '0, 1);
        step(0, '0, 1, 0, 12'd3, 1);
        repeat (4) step(1, rnd_tlp(), 0, 0, '0, 1);
        step(0, '0, 1, 0, 12'd4, 1);
        idle(1, 1);
        obs_seq.delete();
        step(0, '0, 1, 1, 12'd5, 1);
        idle(6, 1);
        check("nak_n", obs_seq.size(), 2);
        check("nak_seq_a", obs_seq[0], 6);
        check("nak_seq_b", obs_seq[1], 7);
        check("nak_back_normal", ack_nak_ready_o, 1);

        // timeout replays and replay-number rollover
        do_reset();
        obs_seq.delete();
        n_retrain = 0;
        step(1, rnd_tlp(), 0, 0, '0, 1);
        idle(100, 1);
        check("timeout_xfers", obs_seq.size(), 6);
        check("retrain_pulses", n_retrain, 1);

        // sequence wrap with each TLP acked the next cycle
        do_reset();
        obs_seq.delete();
        for (int i = 0; i < 4098; i++) step(1, rnd_tlp(), 1, 0, m_next_seq - 12'd1, 1);
        check("wrap_n", obs_seq.size(), 4097);
        check("wrap_4095", obs_seq[4095], 4095);
        check("wrap_0", obs_seq[4096], 0);
        step(0, '0, 1, 0, m_next_seq + 12'd5, 1);
        n_acc = 0;
        repeat (5) step(1, rnd_tlp(), 0, 0, '0, 1);
        check("invalid_ack_no_purge", n_acc, 3);

        // randomized traffic with occasional mid-flight reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            s = m_next_seq - 12'(m_buf.size()) + 12'($urandom_range(0, 7)) - 12'd2;
            step($urandom_range(0, 9) < 7, rnd_tlp(), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, s, $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
